synth_param_regs: RTL

Parameter register bank directly downstream of the SPI receiver. Takes each received address/data pair from the receiver's `rx_valid`/`adrs`/`data` outputs and writes it into a shadow bank. On a commit command, it copies the shadow bank atomically into the active bank at the next audio frame boundary. The active bank drives the synth voice/filter parameter bus, so a parameter never changes mid-sample.

---
 rtl/synth_param_pkg.sv | 17 +
 rtl/param_bank.sv | 32 +++
 rtl/synth_param_regs.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/synth_param_pkg.sv
// synth_param_pkg: shared constants and types for the synth parameter register bank.
//   CMD_COMMIT_ADRS  - command address that arms a shadow->active commit
//   CMD_CLRERR_ADRS  - command address that clears the sticky address error
//   DEF_COMMIT_KEY   - default data value that must accompany a commit
//   commit_state_t   - commit FSM states (used when SYNTH_PARAM_SHADOW_EN is defined)
package synth_param_pkg;

  localparam logic [7:0] CMD_COMMIT_ADRS = 8'hFF;
  localparam logic [7:0] CMD_CLRERR_ADRS = 8'hFE;
  localparam logic [7:0] DEF_COMMIT_KEY  = 8'hA5;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } commit_state_t;

endpackage

// File: rtl/param_bank.sv
// param_bank: N_REGS x 8-bit register storage.
//   clk, reset_n  - clock, async active-low reset (clears every register)
//   we, wr_adrs,
//   wr_data       - single-word write port
//   load,
//   load_data     - bulk load of every register in one cycle; wins over we
//   q             - whole bank, register i at q[i]
module param_bank #(
  parameter int N_REGS = 64,
  parameter int AW     = $clog2(N_REGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [AW-1:0]          wr_adrs,
  input  logic [7:0]             wr_data,
  input  logic                   load,
  input  logic [N_REGS-1:0][7:0] load_data,
  output logic [N_REGS-1:0][7:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (we) begin
      q[wr_adrs] <= wr_data;
    end
  end

endmodule

// File: rtl/synth_param_regs.sv
// synth_param_regs: parameter register bank fed by the SPI receiver.
//   Each rising edge of rx_valid accepts one adrs/data word:
//     adrs < N_REGS        -> register write
//     adrs == 0xFF + key   -> commit; 0xFF with wrong key -> adrs_err
//     adrs == 0xFE         -> clear adrs_err
//     anything else        -> adrs_err
//   With SYNTH_PARAM_SHADOW_EN defined, writes land in a shadow bank and a
//   commit copies shadow->active on the next frame_tick, so the voice/filter
//   parameters only change on a frame boundary. Without it, writes go
//   straight to the active bank and a commit just pulses commit_done.
// Ports:
//   clk, reset_n            - clock, async active-low reset
//   rx_valid, adrs, data    - receiver word (rx_valid is a level)
//   frame_tick              - audio frame strobe
//   rd_adrs / rd_data       - combinational read of the active bank
//   params                  - active bank, register i at [8i+7:8i]
//   commit_pending          - commit armed, waiting for frame_tick
//   commit_done             - one-cycle pulse when the active bank updates
//   adrs_err                - sticky illegal address / bad key flag
module synth_param_regs
  import synth_param_pkg::*;
#(
  parameter int         N_REGS     = 64,
  parameter logic [7:0] COMMIT_KEY = DEF_COMMIT_KEY
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rx_valid,
  input  logic [7:0]                  adrs,
  input  logic [7:0]                  data,
  input  logic                        frame_tick,
  input  logic [$clog2(N_REGS)-1:0]   rd_adrs,
  output logic [7:0]                  rd_data,
  output logic [N_REGS*8-1:0]         params,
  output logic                        commit_pending,
  output logic                        commit_done,
  output logic                        adrs_err
);

  localparam int AW = $clog2(N_REGS);

  // rx_valid is held for several cycles per word; only its rising edge counts
  logic rx_q;
  logic rx_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_q <= 1'b0;
    else          rx_q <= rx_valid;
  end

  assign rx_rise = rx_valid & ~rx_q;

  // decode
  logic in_range, is_cmd, is_clr, key_ok;
  logic wr_en, commit_cmd, err_set, err_clr;

  assign in_range   = ({1'b0, adrs} < 9'(N_REGS));
  assign is_cmd     = (adrs == CMD_COMMIT_ADRS);
  assign is_clr     = (adrs == CMD_CLRERR_ADRS);
  assign key_ok     = (data == COMMIT_KEY);

  assign wr_en      = rx_rise & in_range;
  assign commit_cmd = rx_rise & is_cmd & key_ok;
  assign err_clr    = rx_rise & is_clr;
  assign err_set    = rx_rise & ((is_cmd & ~key_ok) | (~in_range & ~is_cmd & ~is_clr));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     adrs_err <= 1'b0;
    else if (err_clr) adrs_err <= 1'b0;
    else if (err_set) adrs_err <= 1'b1;
  end

  logic [N_REGS-1:0][7:0] active_q;

`ifdef SYNTH_PARAM_SHADOW_EN

  logic [N_REGS-1:0][7:0] shadow_q;
  commit_state_t          state;
  logic                   copy;

  // copy reads shadow_q as registered, so a write on the copy edge only
  // reaches the shadow bank
  assign copy = (state == ARMED) & frame_tick;

  param_bank #(.N_REGS(N_REGS)) u_shadow (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (wr_en),
    .wr_adrs   (adrs[AW-1:0]),
    .wr_data   (data),
    .load      (1'b0),
    .load_data ('0),
    .q         (shadow_q)
  );

  param_bank #(.N_REGS(N_REGS)) u_active (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (1'b0),
    .wr_adrs   (adrs[AW-1:0]),
    .wr_data   (data),
    .load      (copy),
    .load_data (shadow_q),
    .q         (active_q)
  );

  // a commit accepted on a frame_tick cycle while IDLE only arms, so the
  // copy waits for the following tick; repeat commits while ARMED are no-ops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      commit_done <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        IDLE:  if (commit_cmd) state <= ARMED;
        ARMED: if (frame_tick) begin
                 state       <= IDLE;
                 commit_done <= 1'b1;
               end
        default: state <= IDLE;
      endcase
    end
  end

  assign commit_pending = (state == ARMED);

`else

  logic unused_tick;
  assign unused_tick = frame_tick;

  param_bank #(.N_REGS(N_REGS)) u_active (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (wr_en),
    .wr_adrs   (adrs[AW-1:0]),
    .wr_data   (data),
    .load      (1'b0),
    .load_data ('0),
    .q         (active_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) commit_done <= 1'b0;
    else          commit_done <= commit_cmd;
  end

  assign commit_pending = 1'b0;

`endif

  assign rd_data = active_q[rd_adrs];
  assign params  = active_q;

endmodule
